// File: rtl/mg_div_pkg.sv
// Shared types and defaults for the signed divider slice.
package mg_div_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

endpackage

// File: rtl/mg_sub.sv
// Combinational N-bit subtractor a + ~b + 1 built on a Sklansky prefix carry tree.
module mg_sub #(
   parameter int N = 17
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   localparam int LV = $clog2(N);

   logic [N:0] c;

   // Level 0 holds per-bit generate/propagate; level l merges spans of 2**l bits.
   for (genvar l = 0; l <= LV; l++) begin : lvl
      logic [N-1:0] g;
      logic [N-1:0] p;
      if (l == 0) begin : base
         assign g = a & ~b;
         assign p = a ^ ~b;
      end else begin : tree
         for (genvar i = 0; i < N; i++) begin : node
            if (((i >> (l - 1)) & 1) == 1) begin : mrg
               localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
               assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[J]);
               assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[J];
            end else begin : pas
               assign g[i] = lvl[l-1].g[i];
               assign p[i] = lvl[l-1].p[i];
            end
         end
      end
   end

   // Carry-in is fixed at 1, so every group carry is G | P.
   assign c[0]   = 1'b1;
   assign c[N:1] = lvl[LV].g | lvl[LV].p;
   assign diff   = lvl[0].p ^ c[N-1:0];
   assign borrow = ~c[N];

endmodule

// File: rtl/mg_div16s.sv
// Signed restoring divider with valid/ready handshakes on both sides.
module mg_div16s
   import mg_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic                    div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] dvs_mag;
   logic             dd_neg;
   logic             q_neg;

   logic [WIDTH-1:0] dd_mag;
   logic [WIDTH-1:0] dv_mag;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             sub_unused;

   assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign dv_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

   // Partial remainder for this step: previous remainder shifted with the next dividend bit.
   assign trial = {rem_r, q_r[WIDTH-1]};

   mg_sub #(
      .N(WIDTH + 1)
   ) u_sub (
      .a      (trial),
      .b      ({1'b0, dvs_mag}),
      .diff   (diff),
      .borrow (borrow)
   );

   // A successful trial always leaves a result below the divisor, so the top bit is zero.
   assign sub_unused = diff[WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         dvs_mag     <= '0;
         dd_neg      <= 1'b0;
         q_neg       <= 1'b0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     q_r         <= dd_mag;
                     dvs_mag     <= dv_mag;
                     rem_r       <= '0;
                     dd_neg      <= dividend[WIDTH-1];
                     q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     cnt         <= CW'(WIDTH);
                     div_by_zero <= 1'b0;
                     state       <= CALC;
                  end
               end
            end
            CALC: begin
               rem_r <= borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
               q_r   <= {q_r[WIDTH-2:0], ~borrow};
               cnt   <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               // Negating a zero magnitude yields zero, so a zero remainder keeps no sign.
               quotient  <= q_neg  ? -q_r  : q_r;
               remainder <= dd_neg ? -rem_r : rem_r;
               state     <= DONE;
            end
            DONE: begin
               // out_valid rises one cycle after entry and is dropped only at handoff.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mg_div16s.sv
// Randomized scoreboard bench for mg_div16s against an integer-arithmetic reference model.
module tb_mg_div16s;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   mg_div16s #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          rdy_mode = 0;
   logic        prev_ov = 1'b0;
   logic        chk_ir = 1'b0;
   logic [15:0] held_q, held_r;
   logic        held_dz;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain signed integer division, truncating toward zero.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   ai, bi;
      ai = int'($signed(a));
      bi = int'($signed(b));
      e.acc = 0;
      if (bi == 0) begin
         e.q = 16'hFFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
      end else begin
         e.q = 16'(ai / bi); e.r = 16'(ai % bi); e.dz = 1'b0; e.lat = 18;
      end
      return e;
   endfunction

   task automatic stepc();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input bit push);
      exp_t e;
      bit   got;
      got = 0;
      in_valid = 1'b1; dividend = a; divisor = b;
      for (int n = 0; n < 300 && !got; n++) begin
         if (in_ready) begin
            got = 1;
            if (push) begin
               e = model(a, b);
               e.acc = cyc + 1;
               sb.push_back(e);
            end
         end
         stepc();
      end
      in_valid = 1'b0;
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && sb.size() != 0; n++) stepc();
      chk("drain", sb.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_quotient"}, quotient, 0);
      chk({tag, "_remainder"}, remainder, 0);
      chk({tag, "_dbz"}, div_by_zero, 0);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ov = 1'b0;
            chk_ir  = 1'b0;
         end else if (out_valid) begin
            if (!prev_ov) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 32'd1, 32'd0);
               end else begin
                  chk("latency", cyc - sb[0].acc, sb[0].lat);
               end
               held_q = quotient; held_r = remainder; held_dz = div_by_zero;
            end else begin
               chk("hold_quotient", quotient, held_q);
               chk("hold_remainder", remainder, held_r);
               chk("hold_dbz", div_by_zero, held_dz);
            end
            chk("in_ready_busy", in_ready, 0);
            if (out_ready && sb.size() != 0) begin
               chk("quotient", quotient, sb[0].q);
               chk("remainder", remainder, sb[0].r);
               chk("div_by_zero", div_by_zero, sb[0].dz);
               void'(sb.pop_front());
               chk_ir = 1'b1;
            end
            prev_ov = !out_ready;
         end else begin
            if (chk_ir) chk("in_ready_after_handoff", in_ready, 1);
            chk_ir  = 1'b0;
            prev_ov = 1'b0;
         end
      end
   endtask

   task automatic run_main();
      int          ov_seen;
      logic [15:0] a, b;
      rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
      repeat (3) stepc();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      stepc();

      // Directed signed cases and boundaries.
      send(16'd100, 16'd7, 1);
      send(-16'sd100, 16'd7, 1);
      send(16'd100, -16'sd7, 1);
      send(-16'sd100, -16'sd7, 1);
      send(16'h8000, 16'hFFFF, 1);
      send(16'h8000, 16'd1, 1);
      send(16'd5, 16'd0, 1);
      send(16'd14, 16'd7, 1);
      drain();

      // Backpressure with ignored in_valid pulses while busy.
      rdy_mode = 2;
      send(16'd1000, 16'd3, 1);
      in_valid = 1'b1; dividend = 16'd77; divisor = 16'd5;
      repeat (3) stepc();
      in_valid = 1'b0;
      begin
         bit seen;
         seen = 0;
         for (int n = 0; n < 40 && !seen; n++) begin
            if (out_valid) seen = 1; else stepc();
         end
         chk("bp_out_valid_seen", seen, 1);
      end
      repeat (5) stepc();
      rdy_mode = 0;
      drain();

      // Reset during CALC discards the operation.
      send(16'd1234, 16'd7, 0);
      repeat (8) stepc();
      rst_n = 1'b0;
      stepc();
      rst_n = 1'b1;
      chk_reset_vals("midrst");
      ov_seen = 0;
      repeat (25) begin
         stepc();
         if (out_valid) ov_seen++;
      end
      chk("midrst_no_output", ov_seen, 0);
      send(16'd9, 16'd3, 1);
      drain();

      // Randomized operands and consumer stalls.
      rdy_mode = 1;
      for (int k = 0; k < 80; k++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 7))
            0: b = 16'd0;
            1: b = 16'hFFFF;
            2: b = 16'd1;
            3: b = 16'($urandom_range(1, 20));
            4: b = -16'($urandom_range(1, 20));
            default: b = 16'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) a = 16'h8000;
         send(a, b, 1);
      end
      rdy_mode = 0;
      drain();
   endtask

   initial begin
      fork
         monitor();
         begin
            run_main();
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
         end
      join
   end

endmodule
